stack_guard_unit: RTL

//  Watches every write to the stack-pointer register and flags stack overflow or underflow against a fixed window.

---
 rtl/stack_guard_pkg.sv | 22 ++
 rtl/stack_guard_unit_sat_counter.sv | 22 ++
 rtl/stack_guard_unit.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/stack_guard_pkg.sv
// Shared types and defaults for the stack guard: FSM state encoding, fault cause codes
// and the default stack window bounds.
package stack_guard_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_FAULT = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'b00,
    CAUSE_OVF  = 2'b01,
    CAUSE_UNF  = 2'b10,
    CAUSE_MIS  = 2'b11
  } cause_t;

  localparam logic [31:0] DEF_STACK_TOP   = 32'h100103FC;
  localparam logic [31:0] DEF_STACK_LIMIT = 32'h10010000;

endpackage

// File: rtl/stack_guard_unit_sat_counter.sv
// Saturating up-counter: increments on inc and holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register, sticks at its maximum value
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/stack_guard_unit.sv
// Stack guard: checks every SP write against [STACK_LIMIT, STACK_TOP] and raises a sticky, acked fault.
// Optional alignment check is enabled by defining STACK_GUARD_ALIGN_CHECK_EN.
module stack_guard_unit
  import stack_guard_pkg::*;
#(
  parameter int           N           = 32,
  parameter logic [N-1:0] STACK_TOP   = N'(DEF_STACK_TOP),
  parameter logic [N-1:0] STACK_LIMIT = N'(DEF_STACK_LIMIT),
  parameter int           CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sp_we,
  input  logic [N-1:0]     sp_wdata,
  input  logic             guard_en,
  input  logic             fault_ack,
  output logic             fault,
  output logic [1:0]       fault_cause,
  output logic [N-1:0]     fault_addr,
  output logic [N-1:0]     low_water,
  output logic [CNT_W-1:0] viol_count
);

  state_t state_r;
  logic   ovf_s;
  logic   unf_s;
  logic   mis_s;
  logic   viol_s;
  cause_t cause_s;
  logic   count_inc_s;

  // Classify the value being loaded into SP; range causes win over misalignment
  always_comb begin
    ovf_s   = 1'b0;
    unf_s   = 1'b0;
    mis_s   = 1'b0;
    cause_s = CAUSE_NONE;
    if (sp_we) begin
      ovf_s = (sp_wdata < STACK_LIMIT);
      unf_s = (sp_wdata > STACK_TOP);
`ifdef STACK_GUARD_ALIGN_CHECK_EN
      mis_s = (sp_wdata[1:0] != 2'b00);
`else
      mis_s = 1'b0;
`endif
    end else begin
      ovf_s = 1'b0;
      unf_s = 1'b0;
      mis_s = 1'b0;
    end
    viol_s = ovf_s | unf_s | mis_s;
    if (ovf_s) begin
      cause_s = CAUSE_OVF;
    end else if (unf_s) begin
      cause_s = CAUSE_UNF;
    end else if (mis_s) begin
      cause_s = CAUSE_MIS;
    end else begin
      cause_s = CAUSE_NONE;
    end
  end

  // Violations count in every state except IDLE, including ones coinciding with an ack
  assign count_inc_s = viol_s && (state_r != ST_IDLE);

  // Guard FSM with registered fault, cause and capture address
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      fault       <= 1'b0;
      fault_cause <= CAUSE_NONE;
      fault_addr  <= {N{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (guard_en) begin
            state_r <= ST_ARMED;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ARMED: begin
          if (viol_s) begin
            state_r     <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= cause_s;
            fault_addr  <= sp_wdata;
          end else if (!guard_en) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_ARMED;
          end
        end
        ST_FAULT: begin
          if (fault_ack) begin
            state_r     <= ST_CLEAR;
            fault       <= 1'b0;
            fault_cause <= CAUSE_NONE;
          end else begin
            state_r <= ST_FAULT;
          end
        end
        ST_CLEAR: begin
          if (viol_s) begin
            state_r     <= ST_FAULT;
            fault       <= 1'b1;
            fault_cause <= cause_s;
            fault_addr  <= sp_wdata;
          end else if (guard_en) begin
            state_r <= ST_ARMED;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          fault       <= 1'b0;
          fault_cause <= CAUSE_NONE;
        end
      endcase
    end
  end

  // Low-water mark tracks every SP write regardless of guard state or range
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      low_water <= STACK_TOP;
    end else if (sp_we && (sp_wdata < low_water)) begin
      low_water <= sp_wdata;
    end else begin
      low_water <= low_water;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_viol_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (count_inc_s),
    .count(viol_count)
  );

endmodule
